dsp_result_drain: RTL and testbench
===================================

Name: dsp_result_drain

Overview:
- Consumer end of the dsp MAC interface. The issuer hands A/B/C to dsp; this block tracks every issued MAC through the dsp's fixed pipeline latency and captures the matching P.
- Captured results are buffered in a small FIFO and streamed to the output-buffer writer with a valid/ready handshake and an auto-incrementing word address.
- Credit-based backpressure (issue_ready) guarantees no P is ever dropped.

Parameters:
- LAT, 4, register stages from dsp input to P (A→A1→A2→A3→P).
- DEPTH, 8, result FIFO entries (power of 2, ≥2).
- NUM_WORDS, 16, output words per frame; address wraps after NUM_WORDS-1.
- ADDR_W, 8, width of out_addr; must satisfy 2^ADDR_W ≥ NUM_WORDS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issuer presents a MAC to dsp this cycle.
- issue_ready  out  1  drain can accept one more result; issuer must hold A/B/C unless valid&ready.
- p_in  in  `OUTPUT_BUF_DATASIZE  dsp P output.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  output-buffer writer accepts.
- out_data  out  `OUTPUT_BUF_DATASIZE  result word.
- out_addr  out  ADDR_W  output-buffer word address.
- done  out  1  one-cycle pulse on the handshake of word NUM_WORDS-1.
- ovf  out  1  sticky saturation flag (0 when DRAIN_SAT_EN is absent).

Behaviour:
- Issue edge e0: the rising edge where issue_valid & issue_ready = 1; dsp samples A/B/C on the same edge. The matching P is stable after edge e0+LAT-1 and is captured into the FIFO on edge e0+LAT.
- Tracking: LAT-bit valid shift register, bit0 loaded with the accept at e0. The top bit's output enables the FIFO push of p_in.
- Credit: count = FIFO occupancy + popcount(in-flight shift bits). issue_ready = (count < DEPTH), combinational from registered state only, never from issue_valid.
  - count never exceeds DEPTH, so a push never meets a full FIFO.
  - A same-cycle pop frees a credit only from the next cycle.
- FIFO: show-ahead. out_valid = !empty. out_data = head entry. Pop on out_valid & out_ready.
  - Push and pop in the same cycle: occupancy unchanged; order preserved.
  - Empty with a push: out_valid rises the cycle after the capture edge; no bypass.
- Address: out_addr increments on each handshake.
  - At NUM_WORDS-1 a handshake wraps it to 0 and pulses done for exactly the following cycle.
- Reset (async assert, sync release): shift register, FIFO pointers, storage, out_addr, done and ovf all go to 0. After reset: out_valid=0, out_data=0, issue_ready=1.
  - Reset mid-operation discards in-flight and buffered results.
  - The dsp itself has no reset. P values arriving after reset are ignored because no valid bit tracks them.
- Results are unsigned, as produced by the dsp (A*B+C, unsigned Verilog arithmetic). The drain does not modify the value unless DRAIN_SAT_EN is defined.

Optional Feature:
- Macro DRAIN_SAT_EN.
- Defined: at push, p_in is saturated to `OUTPUT_BUF_DATASIZE-1 bits. If the MSB is set, the stored value is 2^(W-1)-1, zero-extended, and ovf is set sticky until reset. This keeps results legal as the dsp C input when chaining.
- Undefined: full-width P is stored; ovf is tied to 0.

Decomposition:
- `DATASIZE and `OUTPUT_BUF_DATASIZE come from the shared config header.
- Add LAT default and DRAIN_DEPTH to the same header so the issuer and the drain agree.
- One sub-module: drain_fifo (parameterised sync show-ahead FIFO, async active-low reset), reusable by the input-buffer path.
- Credit counter, valid shift register and address logic stay in dsp_result_drain.

Test Plan:
- Bench instantiates dsp + drain. Issue A=3, B=5, C=7 once, out_ready=1 → out_data=22, out_addr=0, out_valid high exactly 1 cycle, first seen at e0+LAT+1.
- out_ready=0, issue_valid held high → exactly 8 accepts, then issue_ready=0. Raise out_ready → 8 results in issue order, addresses 0..7, issue_ready returns the cycle after the first pop.
- NUM_WORDS=4, 5 results with out_ready=1 → out_addr 0,1,2,3,0; done pulses once, the cycle after the addr-3 handshake.
- Full FIFO with simultaneous push and pop (out_ready=1 on the cycle a capture lands) → no loss or duplication; data matches a scoreboard; occupancy stays ≤8.
- rst_n pulsed low with 3 in flight and 2 buffered → out_valid=0, out_addr=0, issue_ready=1 immediately; no stale result emitted afterwards.
- DRAIN_SAT_EN with `OUTPUT_BUF_DATASIZE=32 and a forced P of 0x8000_0001 → out_data=0x7FFF_FFFF, ovf=1 and stays 1. Without the macro → out_data=0x8000_0001, ovf=0.

Source files
------------

// File: rtl/dsp_result_drain_pkg.sv
// Shared configuration and types for the dsp result drain.
//
// Purpose:
//   Provides the shared dsp configuration used by both the issuer and the
//   drain, so both sides agree on data widths, pipeline latency and the
//   depth of the result buffer. Each setting can be overridden from the
//   build command line.
//     `DATASIZE            width of the dsp A/B/C inputs
//     `OUTPUT_BUF_DATASIZE width of the dsp P output / output-buffer word
//     `DSP_LAT             register stages from dsp input to P
//     `DRAIN_DEPTH         result FIFO entries in the drain
//
//   Also provides the word type and the saturation helper that is used when
//   the drain is built with DRAIN_SAT_EN.
//
// Ports: none (package).

`ifndef DATASIZE
`define DATASIZE 16
`endif

`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif

`ifndef DSP_LAT
`define DSP_LAT 4
`endif

`ifndef DRAIN_DEPTH
`define DRAIN_DEPTH 8
`endif

package dsp_result_drain_pkg;

  localparam int DSP_IN_W            = `DATASIZE;
  localparam int DRAIN_DATA_W        = `OUTPUT_BUF_DATASIZE;
  localparam int DSP_LAT_DEFAULT     = `DSP_LAT;
  localparam int DRAIN_DEPTH_DEFAULT = `DRAIN_DEPTH;

  typedef logic [DRAIN_DATA_W-1:0] drain_word_t;

  // Clamp a result into DRAIN_DATA_W-1 bits so that it remains a legal
  // (non-negative when viewed as signed) dsp C input when results are chained.
  function automatic drain_word_t drain_saturate(input drain_word_t p);
    drain_word_t sat_max;
    sat_max = {1'b0, {(DRAIN_DATA_W-1){1'b1}}};
    return p[DRAIN_DATA_W-1] ? sat_max : p;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Parameterised synchronous show-ahead FIFO.
//
// Purpose:
//   Small result buffer. The head entry is always visible on 'head', so a
//   consumer can read data and pop in the same cycle. A write and a read
//   in the same cycle leave the occupancy unchanged and preserve order.
//   A write into an empty FIFO becomes visible the cycle after the write
//   edge (no write-to-read bypass).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (pointers and storage cleared)
//   push       in   write push_data this cycle
//   push_data  in   WIDTH-bit data to write
//   pop        in   drop the head entry this cycle
//   empty      out  no entries stored
//   head       out  oldest entry (storage contents when empty)
//   count      out  current occupancy, 0..DEPTH
//
// Parameters:
//   WIDTH  data width
//   DEPTH  number of entries, power of two, at least 2

module drain_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       empty,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit, so full and empty are told apart
  // by the difference alone.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Writes into a full FIFO and reads from an empty one are ignored, which
  // keeps the pointers consistent even if a user breaks the protocol.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_result_drain.sv
// Consumer end of the dsp MAC interface.
//
// Purpose:
//   Tracks every MAC accepted by the dsp through its fixed pipeline latency,
//   captures the matching P into a small FIFO and streams the results to the
//   output-buffer writer with a valid/ready handshake and an auto-incrementing
//   word address. Credit-based backpressure on issue_ready ensures that
//   a captured P always finds room in the FIFO.
//
// Build option:
//   DRAIN_SAT_EN  when defined, each captured P is saturated to
//                 OUTPUT_BUF_DATASIZE-1 bits and 'ovf' records (sticky) that a
//                 saturation happened. When undefined, P is stored unchanged
//                 and 'ovf' is tied low.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   issue_valid  in   issuer presents a MAC to the dsp this cycle
//   issue_ready  out  one more result can be accepted
//   p_in         in   dsp P output
//   out_valid    out  out_data/out_addr valid
//   out_ready    in   output-buffer writer accepts
//   out_data     out  result word (FIFO head)
//   out_addr     out  output-buffer word address
//   done         out  one-cycle pulse after the handshake of word NUM_WORDS-1
//   ovf          out  sticky saturation flag
//
// Parameters:
//   LAT        dsp register stages from input to P
//   DEPTH      result FIFO entries (power of two, at least 2)
//   NUM_WORDS  words per frame; out_addr wraps after NUM_WORDS-1
//   ADDR_W     out_addr width, 2**ADDR_W >= NUM_WORDS

module dsp_result_drain
  import dsp_result_drain_pkg::*;
#(
  parameter int LAT       = DSP_LAT_DEFAULT,
  parameter int DEPTH     = DRAIN_DEPTH_DEFAULT,
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [DRAIN_DATA_W-1:0] p_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DRAIN_DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    done,
  output logic                    ovf
);

  localparam int FAW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + LAT + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  logic [LAT-1:0]          inflight;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic [FAW:0]            fifo_count;
  logic [CW-1:0]           inflight_cnt;
  logic [CW-1:0]           credit;
  logic [DRAIN_DATA_W-1:0] push_data;

  assign accept    = issue_valid & issue_ready;
  assign push      = inflight[LAT-1];
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // One bit per dsp stage: bit 0 is loaded on the edge where the dsp samples
  // A/B/C, so the top bit is set exactly while P for that MAC is on p_in and
  // gets captured on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      inflight <= (inflight << 1) | LAT'(accept);
    end
  end

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_cnt = inflight_cnt + CW'(inflight[i]);
    end
  end

  // Every accepted MAC holds a credit from issue until its result is popped.
  // Only registered state feeds this, so a pop frees its credit from the
  // next cycle, and the FIFO can never be full when a capture arrives.
  assign credit      = CW'(fifo_count) + inflight_cnt;
  assign issue_ready = (credit < CW'(DEPTH));

`ifdef DRAIN_SAT_EN
  logic ovf_q;

  assign push_data = drain_saturate(p_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (push && p_in[DRAIN_DATA_W-1]) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign push_data = p_in;
  assign ovf       = 1'b0;
`endif

  drain_fifo #(
    .WIDTH (DRAIN_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (out_data),
    .count     (fifo_count)
  );

  // The address advances on each handshake and wraps after the last word of
  // the frame; done marks the cycle that follows the last word's handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr <= '0;
      done     <= 1'b0;
    end else begin
      done <= pop && (out_addr == LAST_ADDR);
      if (pop) begin
        out_addr <= (out_addr == LAST_ADDR) ? '0 : out_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dsp_result_drain.sv
// Self-checking bench for dsp_result_drain.
//
// Purpose:
//   Drives the drain from a behavioural stand-in for the dsp (LAT-stage
//   pipeline computing A*B+C) and checks it two ways: directed sequences
//   with expected values worked out by hand, and a reference model that
//   runs every cycle. The model keeps the issued MACs as
//   {value, due cycle} records plus a queue for the buffered results, and
//   derives the credit, address and done behaviour from those queues.
//
// Ports: none (top-level bench).

module tb_dsp_result_drain;
  import dsp_result_drain_pkg::*;

  localparam int W         = DRAIN_DATA_W;
  localparam int IW        = DSP_IN_W;
  localparam int LAT       = DSP_LAT_DEFAULT;
  localparam int DEPTH     = DRAIN_DEPTH_DEFAULT;
  localparam int NUM_WORDS = 16;
  localparam int ADDR_W    = 8;

  typedef struct {
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic [IW-1:0] c;
    logic [W-1:0]  exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] val;
    int           due;
  } pend_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [IW-1:0]     a = '0;
  logic [IW-1:0]     b = '0;
  logic [IW-1:0]     c = '0;
  logic              ovr_en = 1'b0;
  logic [W-1:0]      ovr_val = '0;
  logic [W-1:0]      p_in;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              done;
  logic              ovf;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  // Stand-in for the dsp: A*B+C enters the first stage on the sampling edge
  // and appears on P after LAT edges. ovr_en lets a test force any P value.
  // Like the real dsp, it has no reset.
  logic [W-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= ovr_en ? ovr_val : (W'(a) * W'(b) + W'(c));
    for (int i = 1; i < LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign p_in = pipe[LAT-1];

  dsp_result_drain #(
    .LAT       (LAT),
    .DEPTH     (DEPTH),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .p_in        (p_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .done        (done),
    .ovf         (ovf)
  );

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_output(name, W'(act), W'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic iv, input logic [IW-1:0] ia, input logic [IW-1:0] ib,
                                input logic [IW-1:0] ic, input logic ordy);
    issue_valid = iv;
    a           = ia;
    b           = ib;
    c           = ic;
    out_ready   = ordy;
  endtask

  // The value that should land in the buffer for a dsp result p.
  function automatic logic [W-1:0] stored_value(input logic [W-1:0] p);
`ifdef DRAIN_SAT_EN
    logic [W-1:0] half;
    half = W'(1) << (W - 1);
    if (p >= half) return half - W'(1);
`endif
    return p;
  endfunction

  function automatic logic saturates(input logic [W-1:0] p);
`ifdef DRAIN_SAT_EN
    return p >= (W'(1) << (W - 1));
`else
    return (p != p);
`endif
  endfunction

  // Reference model: compares at the falling edge, then advances its state
  // at the following rising edge from the inputs it saw.
  pend_t        pend_q [$];
  logic [W-1:0] mfifo  [$];
  int           m_addr;
  logic         m_done;
  logic         m_ovf;
  int           cyc;

  initial begin : ref_model
    logic         acc;
    logic         hs;
    logic         in_reset;
    logic         m_ready;
    logic [W-1:0] v;
    pend_t        e;
    cyc    = 0;
    m_addr = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    forever begin
      @(negedge clk);
      in_reset = !rst_n;
      acc      = 1'b0;
      hs       = 1'b0;
      v        = '0;
      if (in_reset) begin
        pend_q.delete();
        mfifo.delete();
        m_addr = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        check_bit("mdl rst out_valid", out_valid, 1'b0);
        check_bit("mdl rst issue_ready", issue_ready, 1'b1);
        check_output("mdl rst out_addr", W'(out_addr), '0);
        check_output("mdl rst out_data", out_data, '0);
        check_bit("mdl rst done", done, 1'b0);
        check_bit("mdl rst ovf", ovf, 1'b0);
      end else begin
        m_ready = (mfifo.size() + pend_q.size()) < DEPTH;
        check_bit("mdl issue_ready", issue_ready, m_ready);
        check_bit("mdl out_valid", out_valid, mfifo.size() != 0);
        if (mfifo.size() != 0) begin
          check_output("mdl out_data", out_data, mfifo[0]);
        end
        check_output("mdl out_addr", W'(out_addr), W'(m_addr));
        check_bit("mdl done", done, m_done);
        check_bit("mdl ovf", ovf, m_ovf);
        acc = issue_valid && m_ready;
        hs  = (mfifo.size() != 0) && out_ready;
        v   = ovr_en ? ovr_val : (W'(a) * W'(b) + W'(c));
      end
      @(posedge clk);
      if (!in_reset && rst_n) begin
        cyc++;
        m_done = 1'b0;
        if (hs) begin
          mfifo.delete(0);
          m_done = (m_addr == NUM_WORDS - 1);
          m_addr = (m_addr == NUM_WORDS - 1) ? 0 : m_addr + 1;
        end
        if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
          e = pend_q.pop_front();
          mfifo.push_back(stored_value(e.val));
          if (saturates(e.val)) m_ovf = 1'b1;
        end
        if (acc) begin
          e.val = v;
          e.due = cyc + LAT;
          pend_q.push_back(e);
        end
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin : stim
    vec_t         vecs [4];
    int           words;
    int           k;
    int           n_hs;
    int           done_cnt;
    int           stale;
    logic         acc_now;
    logic         expect_done;
    logic [W-1:0] exp_forced;
    logic         exp_ovf;

    vecs[0] = '{a: 16'd3,     b: 16'd5,     c: 16'd7,     exp: 32'd22};
    vecs[1] = '{a: 16'd100,   b: 16'd200,   c: 16'd5,     exp: 32'd20005};
    vecs[2] = '{a: 16'h1234,  b: 16'h0010,  c: 16'h0001,  exp: 32'h0001_2341};
    vecs[3] = '{a: 16'hFFFF,  b: 16'h0001,  c: 16'hFFFF,  exp: 32'h0001_FFFE};

    words = 0;

    // Reset
    apply_stimulus(1'b0, '0, '0, '0, 1'b0);
    repeat (3) tick();
    check_bit("reset issue_ready", issue_ready, 1'b1);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_output("reset out_addr", W'(out_addr), '0);
    check_output("reset out_data", out_data, '0);
    rst_n = 1'b1;
    tick();

    // Single MACs: latency, data, address and one-cycle valid.
    foreach (vecs[i]) begin
      check_bit("t1 ready before issue", issue_ready, 1'b1);
      apply_stimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
      tick();
      issue_valid = 1'b0;
      repeat (LAT - 1) tick();
      check_bit("t1 valid too early", out_valid, 1'b0);
      tick();
      check_bit("t1 valid", out_valid, 1'b1);
      check_output("t1 data", out_data, vecs[i].exp);
      check_output("t1 addr", W'(out_addr), W'(words % NUM_WORDS));
      tick();
      words++;
      check_bit("t1 valid one cycle", out_valid, 1'b0);
    end

    // Backpressure: exactly DEPTH accepts, then stall; drain in order.
    apply_stimulus(1'b1, IW'(1), IW'(3), IW'(0), 1'b0);
    k = 0;
    for (int t = 0; t < 2 * DEPTH; t++) begin
      acc_now = issue_ready;
      tick();
      if (acc_now) begin
        k++;
        a = IW'(k + 1);
        c = IW'(k);
      end
    end
    issue_valid = 1'b0;
    check_output("t2 accept count", W'(k), W'(DEPTH));
    check_bit("t2 issue_ready low", issue_ready, 1'b0);
    repeat (LAT) tick();
    check_bit("t2 ready low while full", issue_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_bit("t2 valid", out_valid, 1'b1);
      check_output("t2 data", out_data, W'((i + 1) * 3 + i));
      check_output("t2 addr", W'(out_addr), W'(words % NUM_WORDS));
      tick();
      words++;
      if (i == 0) check_bit("t2 ready after first pop", issue_ready, 1'b1);
    end
    check_bit("t2 drained", out_valid, 1'b0);

    // Address wrap and done across the end of the frame.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_bit("t3 ready", issue_ready, 1'b1);
      apply_stimulus(1'b1, IW'(i + 20), IW'(1), IW'(0), 1'b1);
      tick();
    end
    issue_valid = 1'b0;
    n_hs        = 0;
    done_cnt    = 0;
    expect_done = 1'b0;
    for (int t = 0; t < 3 * LAT + 10; t++) begin
      if (done) done_cnt++;
      if (expect_done) check_bit("t3 done after last word", done, 1'b1);
      expect_done = 1'b0;
      if (out_valid) begin
        check_output("t3 addr", W'(out_addr), W'(words % NUM_WORDS));
        expect_done = ((words % NUM_WORDS) == NUM_WORDS - 1);
        words++;
        n_hs++;
      end
      tick();
    end
    check_output("t3 handshakes", W'(n_hs), W'(5));
    check_output("t3 done pulses", W'(done_cnt), W'(1));

    // Reset with 3 results in flight and 2 buffered.
    apply_stimulus(1'b1, IW'(40), IW'(2), IW'(1), 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = IW'(40 + i);
      tick();
    end
    issue_valid = 1'b0;
    tick();
    check_bit("t4 buffered before reset", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("t4 out_valid in reset", out_valid, 1'b0);
    check_output("t4 out_addr in reset", W'(out_addr), '0);
    check_bit("t4 issue_ready in reset", issue_ready, 1'b1);
    tick();
    tick();
    rst_n     = 1'b1;
    words     = 0;
    out_ready = 1'b1;
    stale     = 0;
    for (int t = 0; t < LAT + 10; t++) begin
      if (out_valid) stale++;
      tick();
    end
    check_output("t4 stale results", W'(stale), '0);

    // Forced P with the MSB set.
`ifdef DRAIN_SAT_EN
    exp_forced = 32'h7FFF_FFFF;
    exp_ovf    = 1'b1;
`else
    exp_forced = 32'h8000_0001;
    exp_ovf    = 1'b0;
`endif
    out_ready   = 1'b0;
    ovr_en      = 1'b1;
    ovr_val     = 32'h8000_0001;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    ovr_en      = 1'b0;
    repeat (LAT) tick();
    check_bit("t5 valid", out_valid, 1'b1);
    check_output("t5 data", out_data, exp_forced);
    check_output("t5 addr", W'(out_addr), '0);
    check_bit("t5 ovf", ovf, exp_ovf);
    out_ready = 1'b1;
    tick();
    repeat (3) tick();
    check_bit("t5 ovf sticky", ovf, exp_ovf);
    check_bit("t5 drained", out_valid, 1'b0);

    // Random traffic, checked by the reference model every cycle.
    issue_valid = 1'b0;
    for (int t = 0; t < 800; t++) begin
      acc_now = issue_valid && issue_ready;
      if (acc_now || !issue_valid) begin
        issue_valid = ($urandom_range(3) != 0);
        a = IW'($urandom);
        b = IW'($urandom);
        c = IW'($urandom);
      end
      out_ready = ($urandom_range(2) != 0) || (t % 97 > 80);
      if (t % 150 < 20) out_ready = 1'b0;
      tick();
    end
    issue_valid = 1'b0;
    out_ready   = 1'b1;
    repeat (LAT + DEPTH + 4) tick();
    check_bit("t6 drained", out_valid, 1'b0);
    check_bit("t6 ready at idle", issue_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
